fir_mac_scheduler: RTL and testbench
====================================

# fir_mac_scheduler

Sequencing controller for the multi-lane FIR datapath. It accepts one parallel sample from the input deserializer, writes it into the sample ring buffer, and steps all NUM_PIPELINES MAC lanes through their tap slices. It then triggers the lane-sum reduction and hands the result word to the output serializer. It sits between the serial front-end and the FIR MAC array inside the filter top level.

## Interface
- DATA_WIDTH, 24, sample/coefficient width; informational, no datapath here.
- FIR_DEPTH, 256, total taps; power of two.
- NUM_PIPELINES, 8, MAC lanes; power of two, divides FIR_DEPTH.
- MAC_LATENCY, 2, cycles from last o_mac_en to final lane accumulator update.
- Derived: T = FIR_DEPTH/NUM_PIPELINES (taps per lane); AW = $clog2(FIR_DEPTH).

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  global enable; low pauses the scheduler.
- i_sample_valid  in  1  deserializer holds a complete sample.
- o_sample_ready  out  1  scheduler can accept a sample.
- o_wr_en  out  1  write strobe to sample ring buffer.
- o_wr_addr  out  AW  ring slot being written.
- o_mac_en  out  1  lanes multiply-accumulate this cycle.
- o_mac_clr  out  1  first tap: lanes load product, discard old accumulator.
- o_mac_last  out  1  final tap of the pass.
- o_smp_addr  out  NUM_PIPELINES*AW  packed per-lane sample addresses (lane 0 in LSBs).
- o_coef_addr  out  NUM_PIPELINES*AW  packed per-lane coefficient addresses.
- o_reduce_start  out  1  one-cycle pulse to lane adder tree.
- i_reduce_done  in  1  adder tree result stable.
- o_result_valid  out  1  filtered word ready for serializer.
- i_result_ready  in  1  serializer accepts word.
- o_primed  out  1  FIR_DEPTH samples written since reset; outputs are meaningful.

## Operation
- States: IDLE, WRITE, MAC, FLUSH, REDUCE, OUTPUT.
- IDLE: o_sample_ready = i_en. On i_sample_valid & o_sample_ready, go to WRITE.
- WRITE (1 cycle):
  - o_wr_en=1, o_wr_addr=head.
  - newest<=head; head<=(head+1) mod FIR_DEPTH, wrapping 255->0.
  - Sample counter increments, saturating; o_primed sets when it reaches FIR_DEPTH.
  - Go to MAC with k=0.
- MAC (T cycles, k=0..T-1):
  - o_mac_en=1; o_mac_clr=(k==0); o_mac_last=(k==T-1).
  - For lane l: o_smp_addr[l] = (newest - (l*T+k)) mod FIR_DEPTH.
  - For lane l: o_coef_addr[l] = l*T+k.
  - After k=T-1, go to FLUSH.
- FLUSH: MAC_LATENCY cycles with all strobes 0, then go to REDUCE.
- REDUCE:
  - o_reduce_start=1 in the first REDUCE cycle only.
  - Wait for i_reduce_done, sampled no earlier than the cycle after the pulse.
  - Go to OUTPUT.
- OUTPUT: o_result_valid=1 until i_result_ready is seen high, then go to IDLE.
- i_en=0:
  - State, k, head and flush count hold.
  - o_wr_en, o_mac_en, o_mac_clr, o_mac_last, o_reduce_start forced 0.
  - o_sample_ready=0.
  - o_result_valid holds its value.
- i_sample_valid while busy: ignored; upstream stalls.
- Reset (any time, asynchronous): state IDLE, head=0, newest=0, k=0, counter=0. Every output 0, including o_primed and the address buses.

## Timing
- All outputs are registered.
- Let acceptance edge E0 be where valid & ready are both high. Cycle numbers count from E0:
  - Cycle 1: WRITE.
  - Cycles 2..T+1: MAC.
  - Cycles T+2..T+1+MAC_LATENCY: FLUSH.
  - Cycle T+2+MAC_LATENCY: o_reduce_start. With defaults, MAC is cycles 2..33, FLUSH 34..35, reduce_start cycle 36.
- OUTPUT is entered the cycle after i_reduce_done is sampled high.
- Handshake fires on the edge where o_result_valid & i_result_ready. o_sample_ready rises the following cycle.
- Minimum sample period = T + MAC_LATENCY + 4 cycles, with reduce_done and result_ready immediate.
- Address buses hold their last value outside MAC.

## Configuration
- FIR_SCHED_OVERRUN_CNT_EN defined:
  - Adds outputs o_overrun (sticky) and o_overrun_cnt[15:0].
  - The counter increments every cycle with i_sample_valid=1 & o_sample_ready=0 & i_en=1, saturating at 0xFFFF.
  - Both are cleared only by reset.
- Undefined: these ports and their logic are absent, and busy-cycle valids are silently stalled.

## Test plan
- Reset, i_en=1, one sample: o_wr_en cycle 1 with addr 0; o_mac_en cycles 2..33; clr at cycle 2; last at cycle 33; o_reduce_start cycle 36.
- Check addresses at k=0 and k=31 after first write: lane 3 smp_addr=(0-96)&255=160 and coef 96; lane 3 at k=31 smp 129, coef 127.
- 257 samples: o_primed rises in the WRITE of sample 256. The 257th write uses addr 0 (wrap).
- Hold i_result_ready=0 for 10 cycles: o_result_valid stays high and o_sample_ready stays 0. Ready=1 gives IDLE next cycle.
- Drop i_en for 5 cycles at k=10: strobes go 0 and k stays 10. On resume, o_mac_last comes 5 cycles later than nominal.
- Assert i_rst_n=0 mid-MAC: outputs 0 immediately without a clock. With FIR_SCHED_OVERRUN_CNT_EN, 3 busy valid cycles give o_overrun_cnt=3.

Source files
------------

// File: rtl/fir_mac_scheduler.sv
// Sequencer for the multi-lane FIR datapath: sample write, per-lane tap sweep, flush, reduce and result handoff.
// Optional build macro FIR_SCHED_OVERRUN_CNT_EN adds a sticky overrun flag and a saturating busy-valid counter.
module fir_mac_scheduler #(
  parameter int DATA_WIDTH    = 24,
  parameter int FIR_DEPTH     = 256,
  parameter int NUM_PIPELINES = 8,
  parameter int MAC_LATENCY   = 2,
  localparam int T  = FIR_DEPTH / NUM_PIPELINES,
  localparam int AW = $clog2(FIR_DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_sample_valid,
  output logic                        o_sample_ready,
  output logic                        o_wr_en,
  output logic [AW-1:0]               o_wr_addr,
  output logic                        o_mac_en,
  output logic                        o_mac_clr,
  output logic                        o_mac_last,
  output logic [NUM_PIPELINES*AW-1:0] o_smp_addr,
  output logic [NUM_PIPELINES*AW-1:0] o_coef_addr,
  output logic                        o_reduce_start,
  input  logic                        i_reduce_done,
  output logic                        o_result_valid,
  input  logic                        i_result_ready,
  output logic                        o_primed
`ifdef FIR_SCHED_OVERRUN_CNT_EN
  ,
  output logic                        o_overrun,
  output logic [15:0]                 o_overrun_cnt
`endif
);

  localparam int KW = (T > 1) ? $clog2(T) : 1;
  localparam int FW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam int CW = AW + 1;
  localparam logic [KW-1:0] K_LAST   = KW'(T - 1);
  localparam logic [FW-1:0] F_LAST   = FW'((MAC_LATENCY > 0) ? (MAC_LATENCY - 1) : 0);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIR_DEPTH);

  if ((DATA_WIDTH < 1) || (FIR_DEPTH < 2) || ((FIR_DEPTH & (FIR_DEPTH - 1)) != 0) ||
      (NUM_PIPELINES < 1) || ((NUM_PIPELINES & (NUM_PIPELINES - 1)) != 0) ||
      (NUM_PIPELINES > FIR_DEPTH) || (MAC_LATENCY < 0)) begin : g_param_check
    $error("fir_mac_scheduler: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    MAC    = 3'd2,
    FLUSH  = 3'd3,
    REDUCE = 3'd4,
    OUTPUT = 3'd5
  } state_e;

  state_e                      state_q;
  logic [KW-1:0]               k_q;
  logic [KW-1:0]               k_d;
  logic [FW-1:0]               flush_q;
  logic [AW-1:0]               head_q;
  logic [AW-1:0]               newest_q;
  logic [CW-1:0]               cnt_q;
  logic                        sample_ready_q;
  logic                        wr_en_q;
  logic [AW-1:0]               wr_addr_q;
  logic                        mac_en_q;
  logic                        mac_clr_q;
  logic                        mac_last_q;
  logic                        reduce_start_q;
  logic                        result_valid_q;
  logic                        primed_q;
  logic [NUM_PIPELINES*AW-1:0] smp_addr_q;
  logic [NUM_PIPELINES*AW-1:0] coef_addr_q;
  logic [NUM_PIPELINES*AW-1:0] smp_addr_d;
  logic [NUM_PIPELINES*AW-1:0] coef_addr_d;
  logic                        accept_s;

  assign accept_s = i_en & i_sample_valid & sample_ready_q;

  // Tap step about to be presented: 0 when entering MAC, otherwise the next k.
  always_comb begin
    k_d         = '0;
    smp_addr_d  = '0;
    coef_addr_d = '0;
    if (state_q == MAC) begin
      k_d = k_q + KW'(1);
    end else begin
      k_d = '0;
    end
    for (int l = 0; l < NUM_PIPELINES; l++) begin
      coef_addr_d[l*AW +: AW] = AW'(l * T) + AW'(k_d);
      smp_addr_d[l*AW +: AW]  = newest_q - (AW'(l * T) + AW'(k_d));
    end
  end

  // Scheduler FSM with its bookkeeping and all registered outputs; i_en low freezes progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      k_q            <= '0;
      flush_q        <= '0;
      head_q         <= '0;
      newest_q       <= '0;
      cnt_q          <= '0;
      sample_ready_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      mac_en_q       <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_last_q     <= 1'b0;
      reduce_start_q <= 1'b0;
      result_valid_q <= 1'b0;
      primed_q       <= 1'b0;
      smp_addr_q     <= '0;
      coef_addr_q    <= '0;
    end else if (!i_en) begin
      sample_ready_q <= 1'b0;
      wr_en_q        <= 1'b0;
      mac_en_q       <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_last_q     <= 1'b0;
      reduce_start_q <= 1'b0;
    end else begin
      sample_ready_q <= 1'b0;
      wr_en_q        <= 1'b0;
      mac_en_q       <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_last_q     <= 1'b0;
      reduce_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q   <= WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= head_q;
            newest_q  <= head_q;
            head_q    <= head_q + AW'(1);
            if (cnt_q != CNT_FULL) begin
              cnt_q <= cnt_q + CW'(1);
            end
            primed_q  <= (cnt_q >= (CNT_FULL - CW'(1)));
          end else begin
            sample_ready_q <= 1'b1;
          end
        end
        WRITE: begin
          state_q     <= MAC;
          k_q         <= '0;
          mac_en_q    <= 1'b1;
          mac_clr_q   <= 1'b1;
          mac_last_q  <= (K_LAST == '0);
          smp_addr_q  <= smp_addr_d;
          coef_addr_q <= coef_addr_d;
        end
        MAC: begin
          if (k_q == K_LAST) begin
            flush_q <= '0;
            if (MAC_LATENCY == 0) begin
              state_q        <= REDUCE;
              reduce_start_q <= 1'b1;
            end else begin
              state_q <= FLUSH;
            end
          end else begin
            k_q         <= k_d;
            mac_en_q    <= 1'b1;
            mac_last_q  <= (k_d == K_LAST);
            smp_addr_q  <= smp_addr_d;
            coef_addr_q <= coef_addr_d;
          end
        end
        FLUSH: begin
          if (flush_q == F_LAST) begin
            state_q        <= REDUCE;
            reduce_start_q <= 1'b1;
          end else begin
            flush_q <= flush_q + FW'(1);
          end
        end
        // The pulse cycle is already past the FLUSH edge, so a stale done is never seen early.
        REDUCE: begin
          if (i_reduce_done) begin
            state_q        <= OUTPUT;
            result_valid_q <= 1'b1;
          end else begin
            state_q <= REDUCE;
          end
        end
        OUTPUT: begin
          if (i_result_ready) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            sample_ready_q <= 1'b1;
          end else begin
            state_q <= OUTPUT;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_sample_ready = sample_ready_q;
  assign o_wr_en        = wr_en_q;
  assign o_wr_addr      = wr_addr_q;
  assign o_mac_en       = mac_en_q;
  assign o_mac_clr      = mac_clr_q;
  assign o_mac_last     = mac_last_q;
  assign o_smp_addr     = smp_addr_q;
  assign o_coef_addr    = coef_addr_q;
  assign o_reduce_start = reduce_start_q;
  assign o_result_valid = result_valid_q;
  assign o_primed       = primed_q;

`ifdef FIR_SCHED_OVERRUN_CNT_EN
  logic        overrun_q;
  logic [15:0] overrun_cnt_q;

  // Valid presented while the scheduler is busy: sticky flag plus saturating count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overrun_q     <= 1'b0;
      overrun_cnt_q <= 16'd0;
    end else if (i_en & i_sample_valid & ~sample_ready_q) begin
      overrun_q <= 1'b1;
      if (overrun_cnt_q != 16'hFFFF) begin
        overrun_cnt_q <= overrun_cnt_q + 16'd1;
      end
    end
  end

  assign o_overrun     = overrun_q;
  assign o_overrun_cnt = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Randomized scoreboard bench for fir_mac_scheduler: expectations are queued at sample acceptance
// on an enabled-cycle timeline and consumed by an independent negedge monitor.
module tb_fir_mac_scheduler;
  localparam int FD = 256;
  localparam int NP = 8;
  localparam int ML = 2;
  localparam int T  = FD / NP;
  localparam int AW = $clog2(FD);
  localparam int BW = NP * AW;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_en;
  logic          i_sample_valid;
  logic          o_sample_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic          o_mac_en;
  logic          o_mac_clr;
  logic          o_mac_last;
  logic [BW-1:0] o_smp_addr;
  logic [BW-1:0] o_coef_addr;
  logic          o_reduce_start;
  logic          i_reduce_done;
  logic          o_result_valid;
  logic          i_result_ready;
  logic          o_primed;
`ifdef FIR_SCHED_OVERRUN_CNT_EN
  logic          o_overrun;
  logic [15:0]   o_overrun_cnt;
`endif

  fir_mac_scheduler #(
    .DATA_WIDTH(24), .FIR_DEPTH(FD), .NUM_PIPELINES(NP), .MAC_LATENCY(ML)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_mac_en(o_mac_en), .o_mac_clr(o_mac_clr), .o_mac_last(o_mac_last),
    .o_smp_addr(o_smp_addr), .o_coef_addr(o_coef_addr), .o_reduce_start(o_reduce_start),
    .i_reduce_done(i_reduce_done), .o_result_valid(o_result_valid),
    .i_result_ready(i_result_ready), .o_primed(o_primed)
`ifdef FIR_SCHED_OVERRUN_CNT_EN
    , .o_overrun(o_overrun), .o_overrun_cnt(o_overrun_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int t; logic [AW-1:0] addr; logic primed; } wr_t;
  typedef struct { int t; logic clr; logic last; logic [BW-1:0] smp; logic [BW-1:0] coef; } mac_t;

  wr_t  q_wr[$];
  mac_t q_mac[$];
  int   q_red[$];

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int n_smp    = 0;

  logic p_rst = 1'b0, p_en = 1'b0, p_svalid = 1'b0, p_done = 1'b0, p_rready = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] all_outs();
    logic [255:0] v;
    v = 256'({o_sample_ready, o_wr_en, o_wr_addr, o_mac_en, o_mac_clr, o_mac_last, o_smp_addr,
              o_coef_addr, o_reduce_start, o_result_valid, o_primed});
`ifdef FIR_SCHED_OVERRUN_CNT_EN
    v = v | 256'({o_overrun, o_overrun_cnt});
`endif
    return v;
  endfunction

  // Input values seen by each rising edge, and the count of enabled edges (the scheduler timeline).
  initial forever begin
    @(posedge i_clk);
    p_rst    = i_rst_n;
    p_en     = i_en;
    p_svalid = i_sample_valid;
    p_done   = i_reduce_done;
    p_rready = i_result_ready;
    if (i_rst_n && i_en) en_cnt++;
  end

  // Monitor: applies the reference behaviour to the previous edge's inputs and pops queued expectations.
  initial begin
    logic busy, exp_rv, exp_sr, in_red, cur_primed, hs, acc;
    logic [BW-1:0] last_smp, last_coef;
    int exp_ov;
    wr_t w; mac_t m; int r;
    busy = 0; exp_rv = 0; exp_sr = 0; in_red = 0; cur_primed = 0;
    last_smp = '0; last_coef = '0; exp_ov = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        q_wr.delete(); q_mac.delete(); q_red.delete();
        busy = 0; exp_rv = 0; exp_sr = 0; in_red = 0; cur_primed = 0;
        last_smp = '0; last_coef = '0; exp_ov = 0;
      end else if (p_rst) begin
        hs  = exp_rv && p_rready && p_en;
        acc = exp_sr && p_svalid && p_en;
        if (p_en && p_svalid && !exp_sr && exp_ov < 65535) exp_ov++;
        if (acc) busy = 1;
        if (hs) begin
          busy = 0; exp_rv = 0;
        end else if (in_red && p_en && p_done) begin
          exp_rv = 1; in_red = 0;
        end
        exp_sr = p_en && !busy;
        chk("result_valid", o_result_valid, exp_rv);
        chk("sample_ready", o_sample_ready, exp_sr);
        if (p_en && q_wr.size() > 0 && q_wr[0].t == en_cnt) begin
          w = q_wr.pop_front();
          cur_primed = w.primed;
          chk("wr_en", o_wr_en, 1);
          chk("wr_addr", o_wr_addr, w.addr);
        end else begin
          chk("wr_en_idle", o_wr_en, 0);
        end
        chk("primed", o_primed, cur_primed);
        if (p_en && q_mac.size() > 0 && q_mac[0].t == en_cnt) begin
          m = q_mac.pop_front();
          chk("mac_en", o_mac_en, 1);
          chk("mac_clr", o_mac_clr, m.clr);
          chk("mac_last", o_mac_last, m.last);
          chk("smp_addr", o_smp_addr, m.smp);
          chk("coef_addr", o_coef_addr, m.coef);
          last_smp = m.smp; last_coef = m.coef;
        end else begin
          chk("mac_strobes_idle", {o_mac_en, o_mac_clr, o_mac_last}, 0);
          chk("smp_addr_hold", o_smp_addr, last_smp);
          chk("coef_addr_hold", o_coef_addr, last_coef);
        end
        if (p_en && q_red.size() > 0 && q_red[0] == en_cnt) begin
          r = q_red.pop_front();
          chk("reduce_start", o_reduce_start, 1);
          in_red = 1;
        end else begin
          chk("reduce_start_idle", o_reduce_start, 0);
        end
`ifdef FIR_SCHED_OVERRUN_CNT_EN
        chk("overrun_cnt", o_overrun_cnt, exp_ov);
        chk("overrun", o_overrun, exp_ov != 0);
`endif
      end
    end
  end

  // One sample transaction; pause/abort indices are MAC steps k, negative disables them.
  task automatic run_sample(input int pause_k, input int done_dly, input int rdy_dly,
                            input int busy_hold, input int abort_k);
    int a, g, wi;
    wr_t w;
    mac_t m;
    i_sample_valid = 1'b1;
    g = 0;
    while (!o_sample_ready && g < 200) begin @(negedge i_clk); g++; end
    if (!o_sample_ready) begin
      chk("accept_timeout", 0, 1);
      i_sample_valid = 1'b0;
      return;
    end
    a  = en_cnt + 1;
    wi = n_smp % FD;
    w.t = a; w.addr = AW'(wi); w.primed = (n_smp + 1 >= FD);
    q_wr.push_back(w);
    for (int k = 0; k < T; k++) begin
      m.t = a + 1 + k; m.clr = (k == 0); m.last = (k == T - 1); m.smp = '0; m.coef = '0;
      for (int l = 0; l < NP; l++) begin
        m.coef[l*AW +: AW] = AW'(l * T + k);
        m.smp[l*AW +: AW]  = AW'(((wi - (l * T + k)) % FD + FD) % FD);
      end
      q_mac.push_back(m);
    end
    q_red.push_back(a + 1 + T + ML);
    n_smp++;
    @(negedge i_clk);
    repeat (busy_hold) @(negedge i_clk);
    i_sample_valid = 1'b0;
    if (abort_k >= 0) begin
      g = 0;
      while (en_cnt < a + 1 + abort_k && g < 200) begin @(negedge i_clk); g++; end
      #2 i_rst_n = 1'b0;
      #1 chk("async_reset_outputs", all_outs(), 0);
      @(negedge i_clk);
      #2 i_rst_n = 1'b1;
      n_smp = 0;
      @(negedge i_clk);
      return;
    end
    if (pause_k >= 0) begin
      g = 0;
      while (en_cnt < a + 1 + pause_k && g < 200) begin @(negedge i_clk); g++; end
      i_en = 1'b0;
      repeat (5) @(negedge i_clk);
      i_en = 1'b1;
    end
    g = 0;
    while (!o_reduce_start && g < 200) begin @(negedge i_clk); g++; end
    if (!o_reduce_start) begin
      chk("reduce_timeout", 0, 1);
      return;
    end
    repeat (done_dly) @(negedge i_clk);
    i_reduce_done = 1'b1;
    g = 0;
    while (!o_result_valid && g < 50) begin @(negedge i_clk); g++; end
    i_reduce_done = 1'b0;
    if (!o_result_valid) begin
      chk("result_timeout", 0, 1);
      return;
    end
    repeat (rdy_dly) @(negedge i_clk);
    i_result_ready = 1'b1;
    @(negedge i_clk);
    i_result_ready = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_en = 1'b1; i_sample_valid = 1'b0;
    i_reduce_done = 1'b0; i_result_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", all_outs(), 0);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);
    run_sample(-1, 0, 0, 0, -1);
    run_sample(10, 1, 10, 0, -1);
    for (int i = 2; i < 257; i++) begin
      run_sample(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, T - 1)) : -1,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), -1);
    end
    run_sample(-1, 0, 0, 0, 5);
    run_sample(-1, 2, 1, 3, -1);
`ifdef FIR_SCHED_OVERRUN_CNT_EN
    chk("overrun_cnt_three", o_overrun_cnt, 3);
`endif
    repeat (4) @(negedge i_clk);
    chk("wr_queue_drained", q_wr.size(), 0);
    chk("mac_queue_drained", q_mac.size(), 0);
    chk("reduce_queue_drained", q_red.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
